ysyx_25040101_lsu: RTL
======================

Name: ysyx_25040101_lsu

Overview:
Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address, along with store data and access type from the control unit. It runs one memory transaction per request over a valid/ready memory port and returns aligned, sign- or zero-extended load data for register writeback. It is multi-cycle: the core stalls until resp_valid_o.

Parameters:
MEM_AW, 32, memory address width; ADDR_W equals MEM_AW.
DATA_W, 32, data width; fixed at 32, and other values are unsupported.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  core request valid
req_ready_o  out  1  LSU can accept a request
req_wen_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned)
req_unsigned_i  in  1  load zero-extend (LBU/LHU)
addr_i  in  32  effective address, from the ALU result
wdata_i  in  32  store data (rs2)
resp_valid_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load data; 0 for stores
err_o  out  1  misaligned/reserved access; valid with resp_valid_o
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts the request
mem_addr_o  out  32  word-aligned address ({addr[31:2], 2'b00})
mem_wen_o  out  1  write enable
mem_wdata_o  out  32  lane-replicated store data
mem_wstrb_o  out  4  byte strobes
mem_resp_valid_i  in  1  read data / write acknowledge
mem_rdata_i  in  32  read word

Behaviour:
- Reset (async, while rst_n_i=0):
  - state = IDLE.
  - Held request fields are cleared: wen, size, unsigned, addr, wdata, rdata, err all 0.
  - Outputs during reset: req_ready_o=1; resp_valid_o, mem_req_valid_o, mem_wen_o, err_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; mem_wstrb_o = 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_ready_o=1; all other valids are 0.
  - On req_valid_i: latch wen/size/unsigned/addr/wdata.
  - Misaligned access goes to DONE with err=1 and issues no memory transaction. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid_o=1; mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o come from latched fields and stay stable until the handshake.
  - On mem_req_ready_i go to WAIT. mem_req_valid_o never drops before ready.
- WAIT:
  - On mem_resp_valid_i go to DONE.
  - For loads, latch the extracted data. Stores ignore mem_rdata_i and rdata is 0.
- DONE:
  - resp_valid_o=1 for exactly one cycle, with rdata_o/err_o valid; then go to IDLE.
  - rdata_o/err_o hold their value until the next accepted request.
- mem_resp_valid_i outside WAIT is ignored.
- req_ready_o=0 in REQ, WAIT and DONE; requests presented then are not accepted.
- Store lanes:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << addr[1:0].
  - word: wdata passed through, wstrb = 1111.
  - For loads, wstrb = 0000.
- Load extract:
  - shifted = mem_rdata_i >> (8*addr[1:0]).
  - byte returns shifted[7:0]; half returns shifted[15:0]; word returns shifted.
  - Sign-extend from bit 7/15 unless req_unsigned_i, in which case zero-extend.
- Latency: request accepted at edge N; mem_req_valid_o at N+1.
  - With ready at N+1 and response at N+2, resp_valid_o is high in cycle N+3 (3-cycle minimum).
  - Misaligned: resp_valid_o at N+1.
- Back-to-back: a new request can be accepted at the edge that follows DONE.
- Reset mid-transaction (any state): return to IDLE immediately. mem_req_valid_o drops asynchronously, and no resp_valid_o is issued for the aborted request.

Test Plan:
- Load byte signed, addr=0x8000_0003, mem_rdata=0x80AB_CDEF → mem_addr=0x8000_0000, wstrb=0000, rdata_o=0xFFFF_FF80, err_o=0, resp_valid_o 3 cycles after accept.
- Load half unsigned, addr=0x8000_0002, rdata=0x9234_5678 → rdata_o=0x0000_9234; the same access signed → 0xFFFF_9234.
- Store byte, addr=0x8000_0001, wdata=0x1234_56AB → mem_wdata=0xABAB_ABAB, wstrb=0010, mem_wen=1; hold mem_req_ready_i=0 for 4 cycles → outputs stay stable, then resp_valid_o 1 cycle after mem_resp_valid_i, rdata_o=0.
- Misaligned word, addr=0x8000_0002 → mem_req_valid_o never asserts, resp_valid_o at N+1 with err_o=1; half at odd address → same; size=11 → same.
- Back-to-back word load (addr=0x8000_0004, rdata=0xDEAD_BEEF) then store (addr=0x8000_0008, wdata=0x0BAD_F00D) → 0xDEAD_BEEF returned, then mem_wdata=0x0BAD_F00D with wstrb=1111; req_ready_o low between accept and DONE, spurious mem_resp_valid_i in IDLE/REQ ignored.
- Assert rst_n_i=0 while in WAIT → mem_req_valid_o=0 and req_ready_o=1 immediately, no resp_valid_o; after release a fresh load completes normally.

Source files
------------

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: one valid/ready memory transaction per core request, with
// store lane replication/strobes and aligned, sign/zero-extended load return.
module ysyx_25040101_lsu #(
    parameter int unsigned MEM_AW = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned EXT_B = DATA_W - 8;
    localparam int unsigned EXT_H = DATA_W - 16;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req_ready;
    logic                r_mem_req_valid;
    logic                r_resp_valid;
    logic                r_wen;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [MEM_AW-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_misaligned;
    logic [DATA_W-1:0]   w_lane;
    logic [3:0]          w_wstrb;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_load_ext;

    assign w_accept = (r_state == S_IDLE) && req_valid_i;

    // Misalignment and store lane/strobe generation on the incoming request
    always_comb begin
        w_misaligned = 1'b0;
        w_lane       = wdata_i;
        w_wstrb      = 4'b0000;
        case (req_size_i)
            2'b00: begin
                w_lane  = {4{wdata_i[7:0]}};
                w_wstrb = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                w_misaligned = addr_i[0];
                w_lane       = {2{wdata_i[15:0]}};
                w_wstrb      = 4'b0011 << addr_i[1:0];
            end
            2'b10: begin
                w_misaligned = (addr_i[1:0] != 2'b00);
                w_wstrb      = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
        if (!req_wen_i || w_misaligned) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load data alignment and extension from the latched request
    assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_size)
            2'b00:   w_load_ext = {{EXT_B{w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
            2'b01:   w_load_ext = {{EXT_H{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid_i) w_state_nxt = w_misaligned ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready_i) w_state_nxt = S_WAIT;
            S_WAIT: if (mem_resp_valid_i) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_resp_valid    <= 1'b0;
        end else begin
            r_req_ready     <= (w_state_nxt == S_IDLE);
            r_mem_req_valid <= (w_state_nxt == S_REQ);
            r_resp_valid    <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wen      <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= 4'b0000;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_wen      <= req_wen_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_addr     <= addr_i;
            r_wdata    <= w_lane;
            r_wstrb    <= w_wstrb;
            r_rdata    <= '0;
            r_err      <= w_misaligned;
        end else if (r_state == S_WAIT && mem_resp_valid_i && !r_wen) begin
            r_rdata <= w_load_ext;
        end
    end

    assign req_ready_o     = r_req_ready;
    assign resp_valid_o    = r_resp_valid;
    assign rdata_o         = r_rdata;
    assign err_o           = r_err;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_addr_o      = {r_addr[MEM_AW-1:2], 2'b00};
    assign mem_wen_o       = r_wen;
    assign mem_wdata_o     = r_wdata;
    assign mem_wstrb_o     = r_wstrb;

endmodule
